// File: rtl/if_pc_gen.sv
// if_pc_gen: instruction-fetch program counter generator (BOOT/RUN/HALT FSM).
// Ports: clk/rst (async active-high); redirect_vld/redirect_pc, trap_vld, halt_req,
//   if_ready in; pc, pc_valid, halted, misalign_err, fetch_cnt out (all registered state).
// Latency: one cycle from request to new pc; if_ready low stalls pc in RUN.
module if_pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'hFFFF_FFFC,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              INC       = 4,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_vld,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_vld,
  input  logic             halt_req,
  input  logic             if_ready,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  localparam logic [XLEN-1:0]  INC_V = XLEN'(INC);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_VEC;
      state        <= BOOT;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      misalign_err <= 1'b0;

      // Count the fetch handed over this cycle, even if the pc is being
      // redirected away at the same edge.
      if ((state == RUN) && if_ready) begin
        fetch_cnt <= fetch_cnt + ONE_C;
      end

      if (trap_vld) begin
        pc    <= TRAP_VEC;
        state <= RUN;
      end else if (redirect_vld) begin
        state <= RUN;
        if (redirect_pc[1:0] != 2'b00) begin
          // Misaligned target is converted into a trap entry.
          pc           <= TRAP_VEC;
          misalign_err <= 1'b1;
        end else begin
          pc <= redirect_pc;
        end
      end else begin
        unique case (state)
          BOOT: begin
            if (halt_req) begin
              state <= HALT;
            end else begin
              // First real fetch address; if_ready is irrelevant here
              // because nothing has been offered yet.
              pc    <= RESET_VEC + INC_V;
              state <= RUN;
            end
          end
          RUN: begin
            if (halt_req) begin
              state <= HALT;
            end else if (if_ready) begin
              pc <= pc + INC_V;
            end
          end
          HALT: begin
            // Parked until a trap or redirect arrives.
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: driver pushes expected post-edge state into a
// queue, a monitor pops and compares after every rising edge.
module tb_if_pc_gen;

  logic        clk;
  logic        rst;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        trap_vld;
  logic        halt_req;
  logic        if_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        hlt;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  if_pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .trap_vld     (trap_vld),
    .halt_req     (halt_req),
    .if_ready     (if_ready),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e.vld});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e.mis});
    chk({tag, ".fetch_cnt"}, fetch_cnt, e.cnt);
  endtask

  // Monitor: compare DUT state shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_all("edge", e);
    end
  end

  // Drive inputs for one edge and record what must be visible after it.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic tv,
                      input logic hr, input logic ir,
                      input logic [31:0] epc, input logic ev, input logic eh,
                      input logic em, input logic [31:0] ecnt);
    exp_t e;
    redirect_vld = rv;
    redirect_pc  = rpc;
    trap_vld     = tv;
    halt_req     = hr;
    if_ready     = ir;
    e.pc  = epc;
    e.vld = ev;
    e.hlt = eh;
    e.mis = em;
    e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t rst_e;
    rst_e = '{pc: 32'hFFFF_FFFC, vld: 1'b0, hlt: 1'b0, mis: 1'b0, cnt: 32'd0};

    rst = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    trap_vld     = 1'b0;
    halt_req     = 1'b0;
    if_ready     = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("reset", rst_e);

    // Boot sequence
    rst = 1'b0;
    //   rv    rpc            tv    hr    ir    pc             vld   hlt   mis   cnt
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd1);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd2);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'd3);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd4);
    // Stall three cycles at 0x10, then advance
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd4);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd4);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd4);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 32'd5);
    // Redirect, trap priority, misaligned redirect
    step(1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'd6);
    step(1'b1, 32'h300,      1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd7);
    step(1'b1, 32'h202,      1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'd8);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'd9);
    // Halt at 0x40, ignore if_ready/halt_req, exit by redirect to 0x80
    step(1'b1, 32'h40,       1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'd10);
    step(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'd11);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'd11);
    step(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'd11);
    step(1'b1, 32'h80,       1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'd11);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0084, 1'b1, 1'b0, 1'b0, 32'd12);
    // Halt again, leave by trap
    step(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b1, 1'b0, 32'd13);
    step(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd13);
    // Wrap-around
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd14);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd15);
    // Misaligned redirect, then async reset while the pulse is still high
    step(1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'd16);
    chk("mis_before_rst", {31'd0, misalign_err}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_all("async_rst", rst_e);
    @(negedge clk);
    chk_all("held_rst", rst_e);

    // Release with if_ready low: BOOT still advances, then RUN stalls
    rst = 1'b0;
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd1);

    // Trap on the first edge out of reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'd1);

    // Drain the scoreboard within a bounded number of cycles
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter XLEN, 32, PC width in bits.
REQ-002 The block SHALL have parameter RESET_VEC, 32'hFFFF_FFFC, PC value loaded by reset.
REQ-003 The block SHALL have parameter TRAP_VEC, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
REQ-004 The block SHALL have parameter INC, 4, sequential PC increment.
REQ-005 The block SHALL have parameter CNT_W, 32, width of the fetch counter.

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 The block SHALL have port redirect_vld, input, 1, branch/jump taken request.
REQ-009 The block SHALL have port redirect_pc, input, XLEN, redirect target.
REQ-010 The block SHALL have port trap_vld, input, 1, exception request.
REQ-011 The block SHALL have port halt_req, input, 1, stop fetching (ebreak/end of program).
REQ-012 The block SHALL have port if_ready, input, 1, fetch stage accepts current pc.
REQ-013 The block SHALL have port pc, output, XLEN, current fetch address (registered).
REQ-014 The block SHALL have port pc_valid, output, 1, pc is a real fetch request.
REQ-015 The block SHALL have port halted, output, 1, block is in HALT.
REQ-016 The block SHALL have port misalign_err, output, 1, one-cycle pulse on a misaligned redirect.
REQ-017 The block SHALL have port fetch_cnt, output, CNT_W, count of accepted fetches.

Function
REQ-018 The FSM SHALL have three states: BOOT, RUN and HALT; pc_valid = (state==RUN), halted = (state==HALT).
REQ-019 In BOOT with no trap/redirect, the next edge SHALL load pc <= RESET_VEC+INC and enter RUN, so the first valid pc is RESET_VEC+INC (0 with defaults).
REQ-020 Per-edge priority in BOOT and RUN SHALL be trap_vld > redirect_vld > halt_req > sequential.
REQ-021 trap_vld SHALL load pc <= TRAP_VEC and set state to RUN, from any state.
REQ-022 redirect_vld with redirect_pc[1:0]==0 SHALL load pc <= redirect_pc and set state to RUN.
REQ-023 redirect_vld with redirect_pc[1:0]!=0 SHALL load pc <= TRAP_VEC, set state to RUN, and assert misalign_err for exactly the following cycle.
REQ-024 halt_req in RUN SHALL hold pc and enter HALT on the next edge.
REQ-025 Sequential advance in RUN SHALL be pc <= pc+INC when if_ready=1; otherwise pc is held (stall).
REQ-026 Wrap-around: pc arithmetic SHALL be modulo 2^XLEN.
REQ-027 In HALT, pc SHALL be held and halt_req and if_ready ignored; only trap_vld or redirect_vld exit, per REQ-021..023.
REQ-028 fetch_cnt SHALL increment by 1 on every edge where pc_valid && if_ready, including when a redirect or trap coincides; it wraps modulo 2^CNT_W.
REQ-029 misalign_err SHALL be 0 on every cycle not covered by REQ-023.

Reset
REQ-030 While rst=1, the block SHALL immediately (asynchronously) force pc=RESET_VEC, state=BOOT, pc_valid=0, halted=0, misalign_err=0 and fetch_cnt=0.
REQ-031 Reset asserted mid-operation (in any state, including a pending misalign pulse) SHALL override all inputs; there is no carry-over after release.
REQ-032 The first edge after rst deasserts SHALL apply the BOOT rules of REQ-019/020.

Verification
REQ-033 Boot: release rst, if_ready=1 -> pc sequence FFFF_FFFC(valid=0), 0000_0000, 0000_0004, 0000_0008 (valid=1); fetch_cnt=2 after the third valid edge.
REQ-034 Stall: in RUN at pc=0x10, if_ready=0 for 3 cycles -> pc stays 0x10 and fetch_cnt unchanged; if_ready=1 -> 0x14.
REQ-035 Redirect and priority: redirect_vld=1 with redirect_pc=0x200 -> pc=0x200 next; trap_vld+redirect_vld together -> pc=0x100; redirect_pc=0x202 -> pc=0x100 and a single-cycle misalign_err pulse.
REQ-036 Halt: halt_req at pc=0x40 -> halted=1, pc_valid=0, pc stays 0x40 despite if_ready=1; then redirect_vld to 0x80 -> RUN, pc=0x80.
REQ-037 Wrap and async reset: redirect to 0xFFFF_FFFC, if_ready=1 -> pc=0x0; assert rst between clock edges -> pc=FFFF_FFFC and fetch_cnt=0 without waiting for a clock.
